// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, credit-limited memory requests and a
// DEPTH-entry in-order prefetch queue. Define FETCH_BYPASS_EN for the 0-cycle empty-queue bypass.
module fetch_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 32,
    parameter int ADDR_WIDTH = 21,
    parameter int DEPTH      = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [DATA_WIDTH-1:0] ir_data,
    output logic [PC_WIDTH-1:0]   ir_pc,
    input  logic                  redirect,
    input  logic [PC_WIDTH-1:0]   redirect_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    // Handshakes: a request transfers when imem_req & imem_ready; a response is
    // always accepted when imem_valid; decode takes the head when ir_valid & ir_ready.

    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [CNT_W-1:0]      out_q, out_d;
    logic [CNT_W-1:0]      disc_q, disc_d;
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem_d   [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic head_valid;
    logic resp_keep;
    logic resp_drop;
    logic byp_avail;
    logic byp_take;
    logic push;
    logic pop;

    // Outstanding requests reserve a queue slot, so a response can always be stored.
    assign credit_ok  = ({1'b0, occ_q} + {1'b0, out_q}) < SUM_W'(DEPTH);
    assign imem_req   = reset & ~redirect & credit_ok;
    assign imem_addr  = pc_q[ADDR_WIDTH-1:0];
    assign req_fire   = imem_req & imem_ready;
    assign head_valid = (occ_q != '0);
    assign resp_keep  = imem_valid & (disc_q == '0) & ~redirect;
    assign resp_drop  = imem_valid & (disc_q != '0) & ~redirect;

`ifdef FETCH_BYPASS_EN
    assign byp_avail = reset & ~head_valid & resp_keep;
    assign byp_take  = byp_avail & ir_ready;
    assign ir_valid  = head_valid | byp_avail;

    always_comb begin
        ir_data = '0;
        ir_pc   = '0;
        if (head_valid) begin
            ir_data = data_mem_q[rd_ptr_q];
            ir_pc   = pc_mem_q[rd_ptr_q];
        end else if (byp_avail) begin
            ir_data = imem_rdata;
            ir_pc   = resp_pc_q;
        end
    end
`else
    assign byp_avail = 1'b0;
    assign byp_take  = 1'b0;
    assign ir_valid  = head_valid;

    always_comb begin
        ir_data = '0;
        ir_pc   = '0;
        if (head_valid) begin
            ir_data = data_mem_q[rd_ptr_q];
            ir_pc   = pc_mem_q[rd_ptr_q];
        end
    end
`endif

    assign push = resp_keep & ~byp_take;
    assign pop  = head_valid & ir_ready & ~redirect;

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        out_d      = out_q;
        disc_d     = disc_q;
        data_mem_d = data_mem_q;
        pc_mem_d   = pc_mem_q;

        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d      = redirect_pc;
            resp_pc_d = redirect_pc;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            occ_d     = '0;
            out_d     = out_q - CNT_W'(imem_valid);
            disc_d    = out_q - CNT_W'(imem_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_WIDTH'(1);
            end
            if (push || byp_take) begin
                resp_pc_d = resp_pc_q + PC_WIDTH'(1);
            end
            if (push) begin
                data_mem_d[wr_ptr_q] = imem_rdata;
                pc_mem_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (resp_drop) begin
                disc_d = disc_q - CNT_W'(1);
            end
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
            out_d = out_q + CNT_W'(req_fire) - CNT_W'(imem_valid);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            occ_q     <= '0;
            out_q     <= '0;
            disc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            data_mem_q <= data_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with fixed latency, queue-level
// reference model checked every cycle, plus directed literal expectations.
module tb_fetch_queue;

    localparam int DW    = 16;
    localparam int PW    = 32;
    localparam int AW    = 21;
    localparam int DEPTH = 4;
    localparam logic [PW-1:0] RESET_PC = '0;
    localparam int W = DW + PW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic          imem_ready = 1'b1;
    logic [AW-1:0] imem_addr;
    logic          imem_valid = 1'b0;
    logic [DW-1:0] imem_rdata = '0;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic [DW-1:0] ir_data;
    logic [PW-1:0] ir_pc;
    logic          redirect = 1'b0;
    logic [PW-1:0] redirect_pc = '0;

    fetch_queue #(
        .DATA_WIDTH(DW), .PC_WIDTH(PW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Reference model: fetched-but-unconsumed words as {data, pc}
    logic [W-1:0]  exp_q[$];
    logic [PW-1:0] pc_m;
    logic [PW-1:0] resp_pc_m;
    int            out_m;
    int            disc_m;

    // Memory model: accepted addresses with the cycle their response is due
    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    int            mem_lat = 1;
    bit            mem_stall_en = 1'b0;

    logic [PW-1:0] cons_pc[$];
    logic [DW-1:0] cons_data[$];
    int            req_count = 0;
    int            cyc = 0;
    bit            rst_next = 1'b0;
    int            checks = 0;
    int            failures = 0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pc_m      = RESET_PC;
        resp_pc_m = RESET_PC;
        out_m     = 0;
        disc_m    = 0;
        pend_addr.delete();
        pend_due.delete();
    endtask

    task automatic clear_log();
        cons_pc.delete();
        cons_data.delete();
    endtask

    // One clock cycle: drive at negedge, compare 1 time unit later, advance models.
    task automatic step(input bit rdy, input bit redir, input logic [PW-1:0] rpc);
        bit            byp;
        bit            take;
        bit            exp_req;
        bit            exp_iv;
        logic [DW-1:0] exp_data;
        logic [PW-1:0] exp_pc;
        @(negedge clk);
        reset       = rst_next;
        ir_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_ready  = !(mem_stall_en && (cyc % 4 == 2));
        if (!reset) model_reset();
        if (reset && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = DW'(pend_addr[0]);
        end else begin
            imem_valid = 1'b0;
            imem_rdata = DW'($urandom);
        end
        #1;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = reset && exp_q.size() == 0 && imem_valid && disc_m == 0 && !redirect;
`endif
        exp_req  = reset && !redirect && (exp_q.size() + out_m < DEPTH);
        exp_iv   = reset && (exp_q.size() > 0 || byp);
        exp_data = '0;
        exp_pc   = '0;
        if (exp_q.size() > 0) begin
            {exp_data, exp_pc} = exp_q[0];
        end else if (byp) begin
            exp_data = imem_rdata;
            exp_pc   = resp_pc_m;
        end
        check("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) check("imem_addr", 64'(imem_addr), 64'(pc_m[AW-1:0]));
        check("ir_valid", 64'(ir_valid), 64'(exp_iv));
        check("ir_data", 64'(ir_data), 64'(exp_data));
        check("ir_pc", 64'(ir_pc), 64'(exp_pc));

        if (reset) begin
            if (ir_valid && ir_ready && !redirect) begin
                cons_pc.push_back(ir_pc);
                cons_data.push_back(ir_data);
            end
            if (imem_valid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (imem_req && imem_ready) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + mem_lat);
                req_count++;
            end
            if (redirect) begin
                exp_q.delete();
                out_m     = out_m - int'(imem_valid);
                disc_m    = out_m;
                pc_m      = redirect_pc;
                resp_pc_m = redirect_pc;
            end else begin
                take = byp && ir_ready;
                if (exp_q.size() > 0 && ir_ready) void'(exp_q.pop_front());
                if (imem_valid) begin
                    out_m--;
                    if (disc_m > 0) begin
                        disc_m--;
                    end else begin
                        if (!take) exp_q.push_back({imem_rdata, resp_pc_m});
                        resp_pc_m = resp_pc_m + 1;
                    end
                end
                if (exp_req && imem_ready) begin
                    out_m++;
                    pc_m = pc_m + 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_next = 1'b0;
        repeat (2) step(1'b0, 1'b0, '0);
        rst_next = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // Held in reset
        rst_next = 1'b0;
        repeat (3) step(1'b0, 1'b0, '0);
        check("rst_ir_valid", 64'(ir_valid), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);

        // Streaming with 1-cycle memory, data = address
        rst_next = 1'b1;
        mem_lat  = 1;
        clear_log();
        step(1'b1, 1'b0, '0);
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", 64'(imem_addr), 64'(RESET_PC[AW-1:0]));
        repeat (11) step(1'b1, 1'b0, '0);
        check("stream_count", 64'(cons_pc.size() >= 8), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < cons_pc.size()) begin
                check("stream_pc", 64'(cons_pc[i]), 64'(i));
                check("stream_data", 64'(cons_data[i]), 64'(i));
            end
        end
        mem_stall_en = 1'b1;
        repeat (8) step(1'b1, 1'b0, '0);
        mem_stall_en = 1'b0;
        repeat (4) step(1'b1, 1'b0, '0);

        // Redirect coinciding with a response and a pop
        clear_log();
        step(1'b1, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, '0);
        check("redir_iv_next", 64'(ir_valid), 64'd0);
        check("redir_req_next", 64'(imem_req), 64'd1);
        check("redir_addr_next", 64'(imem_addr), 64'h200);
        repeat (6) step(1'b1, 1'b0, '0);
        check("redir_count", 64'(cons_pc.size() >= 1), 64'd1);
        if (cons_pc.size() >= 1) begin
            check("redir_first_pc", 64'(cons_pc[0]), 64'h200);
            check("redir_first_data", 64'(cons_data[0]), 64'h200);
        end

        // PC wrap
        clear_log();
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        repeat (6) step(1'b1, 1'b0, '0);
        check("wrap_count", 64'(cons_pc.size() >= 2), 64'd1);
        if (cons_pc.size() >= 2) begin
            check("wrap_pc0", 64'(cons_pc[0]), 64'hFFFF_FFFF);
            check("wrap_data0", 64'(cons_data[0]), 64'hFFFF);
            check("wrap_pc1", 64'(cons_pc[1]), 64'h0);
            check("wrap_data1", 64'(cons_data[1]), 64'h0);
        end

        // Decode stalled: credits fill, then drain in order
        do_reset();
        req_count = 0;
        clear_log();
        repeat (10) step(1'b0, 1'b0, '0);
        check("stall_req_count", 64'(req_count), 64'd4);
        check("stall_req_low", 64'(imem_req), 64'd0);
        check("stall_head_valid", 64'(ir_valid), 64'd1);
        check("stall_head_pc", 64'(ir_pc), 64'h0);
        repeat (8) step(1'b1, 1'b0, '0);
        check("drain_count", 64'(cons_pc.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < cons_pc.size()) check("drain_pc", 64'(cons_pc[i]), 64'(i));
        end
        check("drain_resumed", 64'(req_count > 4), 64'd1);

        // Latency 3: redirect with three requests in flight
        do_reset();
        mem_lat = 3;
        clear_log();
        repeat (3) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0100);
        repeat (12) step(1'b1, 1'b0, '0);
        check("lat3_count", 64'(cons_pc.size() >= 2), 64'd1);
        if (cons_pc.size() >= 2) begin
            check("lat3_pc0", 64'(cons_pc[0]), 64'h100);
            check("lat3_data0", 64'(cons_data[0]), 64'h100);
            check("lat3_pc1", 64'(cons_pc[1]), 64'h101);
        end

        // Asynchronous reset mid-burst with three queued words
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() != 3) step(1'b0, 1'b0, '0);
        end
        check("pre_rst_valid", 64'(ir_valid), 64'd1);
        #2;
        reset    = 1'b0;
        rst_next = 1'b0;
        #1;
        check("async_rst_iv", 64'(ir_valid), 64'd0);
        check("async_rst_req", 64'(imem_req), 64'd0);
        check("async_rst_data", 64'(ir_data), 64'd0);
        check("async_rst_pc", 64'(ir_pc), 64'd0);
        model_reset();
        repeat (2) step(1'b1, 1'b0, '0);
        rst_next = 1'b1;
        step(1'b1, 1'b0, '0);
        check("restart_req", 64'(imem_req), 64'd1);
        check("restart_addr", 64'(imem_addr), 64'(RESET_PC[AW-1:0]));
        step(1'b1, 1'b0, '0);
`ifdef FETCH_BYPASS_EN
        check("bypass_same_cycle", 64'(ir_valid), 64'd1);
        check("bypass_pc", 64'(ir_pc), 64'(RESET_PC));
`else
        check("registered_first", 64'(ir_valid), 64'd0);
        step(1'b1, 1'b0, '0);
        check("registered_next", 64'(ir_valid), 64'd1);
        check("registered_pc", 64'(ir_pc), 64'(RESET_PC));
`endif
        repeat (4) step(1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
